// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream valid/ready/payload, downstream payload,
// flush and profiling outputs.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 160,
    parameter int unsigned WEN_W  = 2,
    parameter int unsigned CNT_W  = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [WEN_W-1:0]  in_wen;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [WEN_W-1:0]  out_wen;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output flush, in_valid, in_data, in_wen, out_ready,
        input  in_ready, out_valid, out_data, out_wen, occupancy, bubble_cnt
    );

    modport slave (
        input  flush, in_valid, in_data, in_wen, out_ready,
        output in_ready, out_valid, out_data, out_wen, occupancy, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and saturating bubble counter.
// Define PIPE_SKID_EN to build the 2-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 160,
    parameter int unsigned WEN_W  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input logic            clk,
    input logic            rst,
    pipe_stage_reg_if.slave bus
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q;
    logic              valid_q;
    logic [DATA_W-1:0] main_data_q;
    logic [WEN_W-1:0]  main_wen_q;
    logic [CNT_W-1:0]  bubble_q;

    logic in_ready;
    logic in_fire;
    logic out_fire;

`ifdef PIPE_SKID_EN
    logic              ready_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [WEN_W-1:0]  skid_wen_q;

    assign in_ready = ready_q;
`else
    assign in_ready = !valid_q || bus.out_ready;
`endif

    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            valid_q     <= 1'b0;
            main_data_q <= '0;
            main_wen_q  <= '0;
            bubble_q    <= '0;
`ifdef PIPE_SKID_EN
            ready_q     <= 1'b1;
            skid_data_q <= '0;
            skid_wen_q  <= '0;
`endif
        end else begin
            if (!valid_q && bus.out_ready && (bubble_q != {CNT_W{1'b1}})) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end

            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_q     <= StOne;
                        valid_q     <= 1'b1;
                        main_data_q <= bus.in_data;
                        main_wen_q  <= bus.in_wen;
                    end
                end
                StOne: begin
                    case ({out_fire, in_fire})
                        2'b11: begin
                            main_data_q <= bus.in_data;
                            main_wen_q  <= bus.in_wen;
                        end
                        2'b10: begin
                            state_q <= StEmpty;
                            valid_q <= 1'b0;
                        end
`ifdef PIPE_SKID_EN
                        2'b01: begin
                            state_q     <= StFull;
                            ready_q     <= 1'b0;
                            skid_data_q <= bus.in_data;
                            skid_wen_q  <= bus.in_wen;
                        end
`endif
                        default: ;
                    endcase
                end
`ifdef PIPE_SKID_EN
                StFull: begin
                    if (out_fire) begin
                        state_q     <= StOne;
                        ready_q     <= 1'b1;
                        main_data_q <= skid_data_q;
                        main_wen_q  <= skid_wen_q;
                    end
                end
`endif
                default: begin
                    state_q <= StEmpty;
                    valid_q <= 1'b0;
                end
            endcase

            // Flush overrides any transition above; a beat taken this cycle is dropped.
            if (bus.flush) begin
                state_q <= StEmpty;
                valid_q <= 1'b0;
`ifdef PIPE_SKID_EN
                ready_q <= 1'b1;
`endif
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = valid_q;
    assign bus.out_data   = main_data_q;
    assign bus.out_wen    = main_wen_q & {WEN_W{valid_q}};
    assign bus.occupancy  = state_q;
    assign bus.bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a queue scoreboard; handles both builds
// (PIPE_SKID_EN defined or not).
module tb_pipe_stage_reg;

    localparam int unsigned DW = 16;
    localparam int unsigned WW = 2;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [WW-1:0] wen;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_stage_reg_if #(.DATA_W(DW), .WEN_W(WW), .CNT_W(CW)) bus ();

    pipe_stage_reg #(.DATA_W(DW), .WEN_W(WW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    beat_t       sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned exp_bubble = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the pre-edge state against the model, then advances one clock.
    task automatic cycle();
        logic  exp_ready;
        logic  in_fire;
        logic  out_fire;
        beat_t b;
        #1;
`ifdef PIPE_SKID_EN
        exp_ready = (sb_q.size() != 2);
`else
        exp_ready = (sb_q.size() == 0) || bus.out_ready;
`endif
        if (!rst) begin
            check("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_ready});
            check("out_valid", {31'b0, bus.out_valid}, {31'b0, sb_q.size() != 0});
            check("occupancy", {30'b0, bus.occupancy}, sb_q.size());
        end
        in_fire  = bus.in_valid && exp_ready;
        out_fire = (sb_q.size() != 0) && bus.out_ready;
        if ((sb_q.size() == 0) && bus.out_ready && (exp_bubble < 15)) exp_bubble++;
        if (out_fire && !rst) begin
            b = sb_q.pop_front();
            check("out_data", {16'b0, bus.out_data}, {16'b0, b.data});
            check("out_wen", {30'b0, bus.out_wen}, {30'b0, b.wen});
        end
        if (rst) begin
            sb_q.delete();
            exp_bubble = 0;
        end else if (bus.flush) begin
            sb_q.delete();
        end else if (in_fire) begin
            b.data = bus.in_data;
            b.wen  = bus.in_wen;
            sb_q.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [WW-1:0] w);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_wen   = w;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) cycle();
        check("drain_timeout", sb_q.size(), 0);
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0);

        // Reset
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_out_valid", {31'b0, bus.out_valid}, 0);
        check("rst_out_data", {16'b0, bus.out_data}, 0);
        check("rst_out_wen", {30'b0, bus.out_wen}, 0);
        check("rst_occupancy", {30'b0, bus.occupancy}, 0);
        check("rst_bubble", {28'b0, bus.bubble_cnt}, 0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 1);

        // Write-enable gating
        drive(1'b0, 16'h00ff, 2'b11);
        cycle();
        check("wen_invalid", {30'b0, bus.out_wen}, 0);
        drive(1'b1, 16'h0055, 2'b01);
        cycle();
        drive(1'b0, 16'h0000, 2'b11);
        check("wen_valid", {30'b0, bus.out_wen}, 32'h1);
        bus.out_ready = 1'b1;
        cycle();
        check("wen_after", {30'b0, bus.out_wen}, 0);
        check("bubble_wen", {28'b0, bus.bubble_cnt}, exp_bubble);

        // Streaming 1..8 back-to-back
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DW'(i), WW'(i));
            cycle();
        end
        drive(1'b0, '0, '0);
        check("stream_bubble", {28'b0, bus.bubble_cnt}, exp_bubble);
        check("stream_last", {16'b0, bus.out_data}, 32'h8);
        drain();

        // Backpressure
        bus.out_ready = 1'b0;
`ifdef PIPE_SKID_EN
        drive(1'b1, 16'h000a, 2'b01);
        cycle();
        drive(1'b1, 16'h000b, 2'b10);
        cycle();
        drive(1'b0, '0, '0);
        check("bp_occupancy", {30'b0, bus.occupancy}, 32'h2);
        check("bp_in_ready", {31'b0, bus.in_ready}, 0);
        check("bp_hold", {16'b0, bus.out_data}, 32'ha);
        bus.out_ready = 1'b1;
        cycle();
        check("bp_second", {16'b0, bus.out_data}, 32'hb);
        cycle();
`else
        drive(1'b1, 16'h000a, 2'b01);
        cycle();
        drive(1'b1, 16'h000b, 2'b10);
        cycle();
        check("bp_in_ready", {31'b0, bus.in_ready}, 0);
        check("bp_hold", {16'b0, bus.out_data}, 32'ha);
        bus.out_ready = 1'b1;
        #1;
        check("bp_ready_comb", {31'b0, bus.in_ready}, 1);
        cycle();
        drive(1'b0, '0, '0);
        check("bp_replace", {16'b0, bus.out_data}, 32'hb);
`endif
        drain();

        // Flush while holding, with a beat offered in the flush cycle
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0011, 2'b11);
        cycle();
`ifdef PIPE_SKID_EN
        drive(1'b1, 16'h0022, 2'b11);
        cycle();
        check("fl_full", {30'b0, bus.occupancy}, 32'h2);
`endif
        drive(1'b1, 16'h000c, 2'b11);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        drive(1'b0, '0, '0);
        check("fl_occupancy", {30'b0, bus.occupancy}, 0);
        check("fl_out_valid", {31'b0, bus.out_valid}, 0);
        check("fl_out_wen", {30'b0, bus.out_wen}, 0);

        // Flush with output transfer and accepted input in the same cycle
        drive(1'b1, 16'h0033, 2'b10);
        cycle();
        bus.out_ready = 1'b1;
        drive(1'b1, 16'h000c, 2'b11);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        drive(1'b0, '0, '0);
        check("fl2_occupancy", {30'b0, bus.occupancy}, 0);
        for (int i = 0; i < 3; i++) cycle();

        // Bubble saturation, then reset clears everything
        for (int i = 0; i < 20; i++) cycle();
        check("bubble_sat", {28'b0, bus.bubble_cnt}, 32'd15);
        check("bubble_model", {28'b0, bus.bubble_cnt}, exp_bubble);
        drive(1'b1, 16'h0077, 2'b11);
        cycle();
        drive(1'b0, '0, '0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        check("rst2_bubble", {28'b0, bus.bubble_cnt}, 0);
        check("rst2_out_valid", {31'b0, bus.out_valid}, 0);
        check("rst2_out_data", {16'b0, bus.out_data}, 0);
        check("rst2_out_wen", {30'b0, bus.out_wen}, 0);
        check("rst2_occupancy", {30'b0, bus.occupancy}, 0);
        check("rst2_in_ready", {31'b0, bus.in_ready}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
